// File: rtl/dreg_share_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
// Holds the FSM state type, the requester limit and the round-robin pick function.
package dreg_share_pkg;

    localparam int N_REQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    // First asserted request scanning ptr, ptr+1, ... modulo n; 0 when none.
    function automatic logic [2:0] rr_pick(input logic [N_REQ_MAX-1:0] req,
                                           input logic [2:0]           ptr,
                                           input int                   n);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ_MAX; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && req[idx]) begin
                win   = 3'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/dreg_share_arbiter_if.sv
// Requester-facing bundle of the shared-register arbiter.
// The master side drives requests and data; the slave side is the arbiter.
interface dreg_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       ack;
    logic                   busy;
    logic [WIDTH-1:0]       q;

    modport master (
        output req, wdata,
        input  grant, ack, busy, q
    );

    modport slave (
        input  req, wdata,
        output grant, ack, busy, q
    );
endinterface

// File: rtl/dreg_share_arbiter_shared_dreg.sv
// WIDTH-bit D register with synchronous active-high reset and load enable.
// This is the single storage element shared by all requesters.
module shared_dreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/dreg_share_arbiter.sv
// Round-robin sequencer granting one requester at a time write access to a
// shared register: IDLE picks a winner, WRITE loads its data, ACK pulses ack.
module dreg_share_arbiter
    import dreg_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    dreg_share_arbiter_if.slave bus
);
    state_t           state_reg;
    logic [2:0]       ptr_reg;
    logic [N_REQ-1:0] grant_reg;
    logic [N_REQ-1:0] ack_reg;

    logic [N_REQ_MAX-1:0] req_ext;
    logic [2:0]           pick;
    logic [WIDTH-1:0]     masked_data [N_REQ];
    logic [WIDTH-1:0]     sel_data;

    assign req_ext = N_REQ_MAX'(bus.req);
    assign pick    = rr_pick(req_ext, ptr_reg, N_REQ);

    // grant_reg is one-hot while writing, so an AND-OR mux selects the winner's data.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign masked_data[gi] = grant_reg[gi] ? bus.wdata[gi*WIDTH +: WIDTH] : '0;
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_data = sel_data | masked_data[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            grant_reg <= '0;
            ack_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|bus.req) begin
                        grant_reg <= N_REQ'(1) << pick;
                        ptr_reg   <= (pick == 3'(N_REQ - 1)) ? 3'd0 : pick + 3'd1;
                        state_reg <= WRITE;
                    end
                end
                WRITE: begin
                    ack_reg   <= grant_reg;
                    state_reg <= ACK;
                end
                ACK: begin
                    ack_reg   <= '0;
                    grant_reg <= '0;
                    state_reg <= IDLE;
                end
                default: begin
                    ack_reg   <= '0;
                    grant_reg <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    shared_dreg #(.WIDTH(WIDTH)) u_dreg (
        .clk (clk),
        .rst (rst),
        .en  (state_reg == WRITE),
        .d   (sel_data),
        .q   (bus.q)
    );

    assign bus.grant = grant_reg;
    assign bus.ack   = ack_reg;
    assign bus.busy  = (state_reg != IDLE);
endmodule

// File: tb/tb_dreg_share_arbiter.sv
// Directed bench for dreg_share_arbiter: reset, round-robin, single request,
// wrap/skip, request drop during write and reset in the middle of a write.
module tb_dreg_share_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    dreg_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    dreg_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] a,
                           input logic b, input logic [7:0] qv);
        chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
        chk({tag, ".ack"},   32'(bus.ack),   32'(a));
        chk({tag, ".busy"},  32'(bus.busy),  32'(b));
        chk({tag, ".q"},     32'(bus.q),     32'(qv));
        $display("step %s: grant=%b ack=%b busy=%b q=%h", tag, bus.grant, bus.ack, bus.busy, bus.q);
    endtask

    initial begin
        logic [3:0] oh;
        rst       = 1'b1;
        bus.req   = 4'b1111;
        bus.wdata = {8'h13, 8'h12, 8'h11, 8'h10};

        tick(); chk_all("rst0", 4'b0000, 4'b0000, 1'b0, 8'h00);
        tick(); chk_all("rst1", 4'b0000, 4'b0000, 1'b0, 8'h00);
        rst = 1'b0;

        // All requests held: winners rotate 0,1,2,3,0, one write every 3 cycles.
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            tick(); chk_all($sformatf("rr%0d.e0", k), oh, 4'b0000, 1'b1, (k == 0) ? 8'h00 : 8'(8'h10 + ((k - 1) % 4)));
            tick(); chk_all($sformatf("rr%0d.e1", k), oh, oh,      1'b1, 8'(8'h10 + (k % 4)));
            tick(); chk_all($sformatf("rr%0d.e2", k), 4'b0000, 4'b0000, 1'b0, 8'(8'h10 + (k % 4)));
        end

        // Single request from requester 2 (ptr=1).
        bus.req = 4'b0100;
        bus.wdata[16 +: 8] = 8'hA5;
        tick(); chk_all("single.e0", 4'b0100, 4'b0000, 1'b1, 8'h10);
        tick(); chk_all("single.e1", 4'b0100, 4'b0100, 1'b1, 8'hA5);
        bus.req = 4'b0000;
        tick(); chk_all("single.e2", 4'b0000, 4'b0000, 1'b0, 8'hA5);

        // ptr=3, req 0101: wraps past 3 to 0, then 2.
        bus.req = 4'b0101;
        tick(); chk_all("wrap.e0", 4'b0001, 4'b0000, 1'b1, 8'hA5);
        tick(); chk_all("wrap.e1", 4'b0001, 4'b0001, 1'b1, 8'h10);
        bus.req = 4'b0100;
        tick(); chk_all("wrap.e2", 4'b0000, 4'b0000, 1'b0, 8'h10);
        tick(); chk_all("skip.e0", 4'b0100, 4'b0000, 1'b1, 8'h10);
        tick(); chk_all("skip.e1", 4'b0100, 4'b0100, 1'b1, 8'hA5);
        bus.req = 4'b0000;
        tick(); chk_all("skip.e2", 4'b0000, 4'b0000, 1'b0, 8'hA5);

        // Requester 1 drops its request while in WRITE; write and ack still happen.
        bus.req = 4'b0010;
        bus.wdata[8 +: 8] = 8'h3C;
        tick(); chk_all("drop.e0", 4'b0010, 4'b0000, 1'b1, 8'hA5);
        bus.req = 4'b0000;
        tick(); chk_all("drop.e1", 4'b0010, 4'b0010, 1'b1, 8'h3C);
        tick(); chk_all("drop.e2", 4'b0000, 4'b0000, 1'b0, 8'h3C);
        tick(); chk_all("drop.e3", 4'b0000, 4'b0000, 1'b0, 8'h3C);

        // Load 0x55, then reset while the next write is in WRITE.
        bus.req = 4'b1000;
        bus.wdata[24 +: 8] = 8'h55;
        tick(); chk_all("pre.e0", 4'b1000, 4'b0000, 1'b1, 8'h3C);
        tick(); chk_all("pre.e1", 4'b1000, 4'b1000, 1'b1, 8'h55);
        bus.req = 4'b0000;
        tick(); chk_all("pre.e2", 4'b0000, 4'b0000, 1'b0, 8'h55);
        bus.req = 4'b0001;
        bus.wdata[0 +: 8] = 8'h77;
        tick(); chk_all("mid.e0", 4'b0001, 4'b0000, 1'b1, 8'h55);
        rst = 1'b1;
        tick(); chk_all("mid.rst", 4'b0000, 4'b0000, 1'b0, 8'h00);
        rst = 1'b0;
        // ptr is back at 0, so requester 0 wins over 3.
        bus.req = 4'b1001;
        tick(); chk_all("post.e0", 4'b0001, 4'b0000, 1'b1, 8'h00);
        tick(); chk_all("post.e1", 4'b0001, 4'b0001, 1'b1, 8'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dreg_share_arbiter.md
Name: dreg_share_arbiter

Overview:
Round-robin arbiter that shares one W-bit synchronous-reset D register among N_REQ requesters. Each requester raises a request with write data. The controller grants one requester at a time, writes that requester's data into the shared register and returns a one-cycle acknowledge. The block sits above the flip-flop library cells as the sequencer for any shared status or config register.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, width of shared register and of each requester's write data

Ports:
clk  in  1  single clock; all state updates on posedge clk
rst  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester write request; level, held until matching ack
wdata  in  N_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]; stable while req[i]=1
grant  out  N_REQ  one-hot registered grant; high in WRITE and ACK states
ack  out  N_REQ  one-hot one-cycle pulse; high in ACK state
busy  out  1  high when state != IDLE
q  out  WIDTH  shared register contents

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, ptr=0, grant=0, ack=0, busy=0, q=0. Reset overrides any in-flight transaction: no write, no ack.
- FSM states: IDLE, WRITE, ACK.
- IDLE:
  - If req != 0: winner = first i with req[i]=1, scanning ptr, ptr+1, ... with wrap mod N_REQ.
  - grant <= onehot(winner), ptr <= (winner+1) mod N_REQ, state <= WRITE.
  - If req == 0: hold state and ptr.
- WRITE: q <= wdata[winner], ack <= onehot(winner), state <= ACK. The write completes even if req[winner] dropped in this cycle; there is no abort.
- ACK:
  - ack drops at next edge; grant <= 0, state <= IDLE.
  - The requester deasserts req in the cycle it sees ack=1.
  - req[winner] still high in the following IDLE counts as a new request.
- Latency:
  - req high before edge e0 → grant visible after e0.
  - q updated and ack high after e1.
  - ack low and busy low after e2.
  - Earliest next grant after e3.
  - Throughput: one write per 3 cycles under continuous load.
- q changes only on the WRITE→ACK edge or on reset. At all other times q holds.
- Fairness: with all N_REQ requests held, grants rotate 0,1,...,N_REQ-1,0. No requester waits more than N_REQ transactions.
- Simultaneous events:
  - req changes in WRITE/ACK are ignored until IDLE.
  - rst wins over every FSM transition.
- Invariants: grant and ack are each zero or one-hot. ack=1 implies grant equals ack.

Decomposition:
- Package dreg_share_pkg holds:
  - state typedef (IDLE, WRITE, ACK, 2-bit enum)
  - function rr_pick(req, ptr) returning the winner index
  - N_REQ_MAX = 8 constant
- One sub-module, shared_dreg: WIDTH-bit D register with clk, sync active-high rst, en, d, q. It is instantiated once, with en = (state==WRITE) and d = selected wdata.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 → q=0, grant=0, ack=0, busy=0 throughout; after rst=0, first grant=4'b0001.
- Single request: req[2]=1, wdata[2]=8'hA5 from idle → grant=4'b0100 at e0, q=8'hA5 and ack=4'b0100 at e1, busy=0 at e2.
- Round-robin: req=4'b1111 held, wdata[i]=8'h10+i, each requester re-requests after its ack → ack order 0,1,2,3,0; q sequence 10,11,12,13,10; one ack every 3 cycles.
- Wrap and skip: ptr=3 after granting requester 2, req=4'b0101 → next grant 4'b0001, then 4'b0100.
- Request drop during WRITE: req[1] falls in WRITE with wdata[1]=8'h3C → q=8'h3C and ack[1] still pulses; no further grant to 1.
- Reset mid-transaction: rst=1 in WRITE state with q=8'h55 → after that edge q=0, ack=0, state=IDLE, ptr=0.
